// File: rtl/cbus_mem_pkg.sv
// rtl/cbus_mem_pkg.sv - cache-bus types, responder state encoding and stall LFSR constants
package cbus_mem_pkg;

   typedef enum logic {
      CB_FIXED = 1'b0,
      CB_INCR  = 1'b1
   } cbus_burst_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;
      cbus_burst_t burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } cmr_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps 16,14,13,11 expressed as a mask over q[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          MAX_STALL = 3;

endpackage

// File: rtl/cbus_mem_responder_lfsr16.sv
// rtl/cbus_mem_responder_lfsr16.sv - 16-bit Fibonacci LFSR driving pseudo-random ready stalls
module lfsr16
   import cbus_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] q
);

   // Shift left every cycle, feeding back the XOR of the tapped bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[14:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/cbus_mem_responder.sv
// rtl/cbus_mem_responder.sv - RAM-backed cache-bus responder with latency and bursts (option: CBUS_RESP_STALL_EN)
module cbus_mem_responder
   import cbus_mem_pkg::*;
#(
   parameter int MEM_WORDS = 4096,
   parameter int LATENCY   = 2
)(
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp
);

   localparam int          AW   = $clog2(MEM_WORDS);
   localparam logic [3:0]  LAT4 = 4'(LATENCY);

   logic [31:0]    mem [MEM_WORDS];

   cmr_state_t     state;
   cmr_state_t     state_nx;
   logic [AW-1:0]  base_idx;
   logic [3:0]     len_q;
   logic           wr_q;
   cbus_burst_t    burst_q;
   logic [3:0]     wcnt;
   logic [3:0]     beat;

   logic           stall;
   logic           ready;
   logic           last;
   logic [AW-1:0]  idx;
   logic [31:0]    rdata;

   // size is not interpreted and only the word-index bits of addr matter
   logic unused_req;
   assign unused_req = ^{creq.size, creq.addr[31:AW+2], creq.addr[1:0]};

`ifdef CBUS_RESP_STALL_EN
   logic [15:0] lfsr_q;
   logic [1:0]  stall_cnt;
   logic        unused_lfsr;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[15:1];
   // Stall on LFSR bit 0, but never more than MAX_STALL cycles in a row
   assign stall = (state == BURST) && lfsr_q[0] && (stall_cnt < 2'(MAX_STALL));

   // Count consecutive stalled cycles so the next one can be forced ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= 2'd0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 2'd1;
      end else begin
         stall_cnt <= 2'd0;
      end
   end
`else
   assign stall = 1'b0;
`endif

   // Next-state and response decode; data is forced to zero outside ready read beats
   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      last     = 1'b0;
      rdata    = 32'd0;
      idx      = (burst_q == CB_INCR) ? (base_idx + AW'(beat)) : base_idx;

      if (state == BURST && !stall) begin
         ready = 1'b1;
         last  = (beat == len_q);
         if (!wr_q) begin
            rdata = mem[idx];
         end
      end

      case (state)
         IDLE: begin
            if (creq.valid) begin
               state_nx = (LAT4 == 4'd0) ? BURST : WAIT;
            end
         end
         WAIT: begin
            if (wcnt == 4'd1) begin
               state_nx = BURST;
            end
         end
         BURST: begin
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register plus request latch, latency countdown and beat counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         base_idx <= '0;
         len_q    <= 4'd0;
         wr_q     <= 1'b0;
         burst_q  <= CB_FIXED;
         wcnt     <= 4'd0;
         beat     <= 4'd0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (creq.valid) begin
                  base_idx <= creq.addr[AW+1:2];
                  len_q    <= creq.len;
                  wr_q     <= creq.is_write;
                  burst_q  <= creq.burst;
                  wcnt     <= LAT4;
                  beat     <= 4'd0;
               end
            end
            WAIT: begin
               wcnt <= wcnt - 4'd1;
            end
            BURST: begin
               if (ready) begin
                  beat <= beat + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Byte-lane write of the current beat; the array itself is never reset
   always_ff @(posedge clk) begin
      if (ready && wr_q) begin
         for (int b = 0; b < 4; b++) begin
            if (creq.strobe[b]) begin
               mem[idx][8*b +: 8] <= creq.data[8*b +: 8];
            end
         end
      end
   end

   assign cresp.ready = ready;
   assign cresp.last  = last;
   assign cresp.data  = rdata;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb/tb_cbus_mem_responder.sv - self-checking bench for cbus_mem_responder
module tb_cbus_mem_responder;
   import cbus_mem_pkg::*;

   localparam int MW = 256;
`ifdef CBUS_RESP_STALL_EN
   localparam int LAT   = 0;
   localparam bit STALL = 1'b1;
`else
   localparam int LAT   = 2;
   localparam bit STALL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   cbus_req_t  creq;
   cbus_resp_t cresp;

   cbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .creq  (creq),
      .cresp (cresp)
   );

   always #5 clk = ~clk;

   logic [31:0] ref_mem [MW];
   logic [31:0] wbuf [16];
   logic [31:0] rbuf [16];
   int          n_vec = 0;
   int          n_err = 0;
   int          ready_seen;
   int          last_seen;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      int          len;
      bit          incr;
      logic [3:0]  strb;
      logic [31:0] wbase;
      logic [31:0] exp0;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] addr, input int beat, input bit incr);
      int base;
      base = int'(addr >> 2);
      return incr ? ((base + beat) % MW) : (base % MW);
   endfunction

   // One transaction from the initiator side; returns at the negedge of its final
   // (or abort_at-th) beat with valid still asserted
   task automatic burst(input bit wr, input logic [31:0] addr, input int len, input bit incr,
                        input logic [3:0] strb, input int exp_lat, input int abort_at);
      int cyc;
      int beat;
      int stalls;
      int ix;
      @(negedge clk);
      creq.valid    = 1'b1;
      creq.is_write = wr;
      creq.size     = 3'd2;
      creq.addr     = addr;
      creq.len      = 4'(len);
      creq.burst    = incr ? CB_INCR : CB_FIXED;
      creq.strobe   = strb;
      creq.data     = wbuf[0];
      ready_seen    = 0;
      last_seen     = 0;
      cyc = 0;
      while (!cresp.ready && cyc < 64) begin
         chk("pre_ready_data", cresp.data, 32'd0);
         @(negedge clk);
         cyc++;
      end
      if (!cresp.ready) begin
         chk("first_ready_timeout", {31'd0, cresp.ready}, 32'd1);
         return;
      end
      if (STALL) chk("first_ready_window", 32'(cyc >= exp_lat && cyc <= exp_lat + MAX_STALL), 32'd1);
      else       chk("first_ready_latency", 32'(cyc), 32'(exp_lat));
      beat   = 0;
      stalls = 0;
      for (int t = 0; t < 200; t++) begin
         creq.data = wbuf[beat];
         if (cresp.last) last_seen++;
         if (cresp.ready) begin
            ready_seen++;
            stalls = 0;
            ix = widx(addr, beat, incr);
            chk("last_flag", {31'd0, cresp.last}, 32'(beat == len));
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (strb[b]) ref_mem[ix][8*b +: 8] = wbuf[beat][8*b +: 8];
            end else begin
               chk("rd_data", cresp.data, ref_mem[ix]);
               rbuf[beat] = cresp.data;
            end
            beat++;
            if (beat > len || beat == abort_at) break;
         end else begin
            stalls++;
            chk("stall_outputs_zero", {cresp.data[31:1], cresp.data[0] | cresp.last}, 32'd0);
            if (STALL) chk("stall_run_max3", 32'(stalls <= MAX_STALL), 32'd1);
            else       chk("ready_gap_in_burst", {31'd0, cresp.ready}, 32'd1);
         end
         @(negedge clk);
      end
      if (beat <= len && beat != abort_at) chk("burst_timeout_beats", 32'(beat), 32'(len + 1));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         creq.valid = 1'b0;
         chk("idle_ready_last", {30'd0, cresp.ready, cresp.last}, 32'd0);
         chk("idle_data", cresp.data, 32'd0);
      end
   endtask

   initial begin
      int gap;
      int len;
      logic [31:0] addr;
      bit wr;
      bit incr;
      logic [3:0] strb;

      for (int i = 0; i < MW; i++) ref_mem[i] = 32'd0;
      reset = 1'b1;
      creq  = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {30'd0, cresp.ready, cresp.last}, 32'd0);
      chk("reset_data", cresp.data, 32'd0);
      reset = 1'b0;
      idle(1);

      // Known contents everywhere so nothing depends on power-up state
      for (int blk = 0; blk < MW / 16; blk++) begin
         for (int i = 0; i < 16; i++) wbuf[i] = 32'hC0DE_0000 + 32'(blk * 16 + i);
         burst(1'b1, 32'(blk * 64), 15, 1'b1, 4'hF, 1 + LAT, 99);
         idle(1);
      end

      tbl[0]  = '{1'b1, 32'h100, 0, 1'b1, 4'hF,    32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b0, 32'h100, 0, 1'b1, 4'h0,    32'h0,        32'hDEADBEEF};
      tbl[2]  = '{1'b1, 32'h040, 0, 1'b1, 4'hF,    32'h11223344, 32'h0};
      tbl[3]  = '{1'b1, 32'h040, 0, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h0};
      tbl[4]  = '{1'b0, 32'h040, 0, 1'b1, 4'h0,    32'h0,        32'h11BB33DD};
      tbl[5]  = '{1'b1, 32'h080, 3, 1'b0, 4'hF,    32'h100,      32'h0};
      tbl[6]  = '{1'b0, 32'h080, 0, 1'b1, 4'h0,    32'h0,        32'h103};
      tbl[7]  = '{1'b0, 32'h080, 2, 1'b0, 4'h0,    32'h0,        32'h103};
      tbl[8]  = '{1'b1, 32'h3F8, 3, 1'b1, 4'hF,    32'hA0,       32'h0};
      tbl[9]  = '{1'b0, 32'h3F8, 0, 1'b1, 4'h0,    32'h0,        32'hA0};
      tbl[10] = '{1'b0, 32'h3FC, 0, 1'b1, 4'h0,    32'h0,        32'hA1};
      tbl[11] = '{1'b0, 32'h000, 0, 1'b1, 4'h0,    32'h0,        32'hA2};
      tbl[12] = '{1'b0, 32'h004, 0, 1'b1, 4'h0,    32'h0,        32'hA3};
      tbl[13] = '{1'b0, 32'h3F8, 3, 1'b1, 4'h0,    32'h0,        32'hA0};

      for (int v = 0; v < 14; v++) begin
         for (int i = 0; i < 16; i++) wbuf[i] = tbl[v].wbase + 32'(i);
         burst(tbl[v].wr, tbl[v].addr, tbl[v].len, tbl[v].incr, tbl[v].strb, 1 + LAT, 99);
         if (!tbl[v].wr) chk("table_read_beat0", rbuf[0], tbl[v].exp0);
         chk("table_last_count", 32'(last_seen), 32'd1);
         idle(1);
      end

      // 16-beat INCR write then a back-to-back read: acceptance waits out DONE and IDLE
      for (int i = 0; i < 16; i++) wbuf[i] = 32'(i);
      burst(1'b1, 32'h1C0, 15, 1'b1, 4'hF, 1 + LAT, 99);
      burst(1'b0, 32'h1C0, 15, 1'b1, 4'h0, 2 + LAT, 99);
      for (int i = 0; i < 16; i++) chk("incr16_read", rbuf[i], 32'(i));
      chk("incr16_ready_cycles", 32'(ready_seen), 32'd16);
      chk("incr16_last_count", 32'(last_seen), 32'd1);
      idle(1);

      // 8-beat read: exactly 8 ready cycles carrying one last
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h11 * 32'(i + 1);
      burst(1'b1, 32'h300, 7, 1'b1, 4'hF, 1 + LAT, 99);
      idle(1);
      burst(1'b0, 32'h300, 7, 1'b1, 4'h0, 1 + LAT, 99);
      for (int i = 0; i < 8; i++) chk("read8_data", rbuf[i], 32'h11 * 32'(i + 1));
      chk("read8_ready_cycles", 32'(ready_seen), 32'd8);
      chk("read8_last_count", 32'(last_seen), 32'd1);
      idle(1);

      // Reset after beat 2 of an 8-beat write over a preloaded region
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h7700 + 32'(i);
      burst(1'b1, 32'h200, 7, 1'b1, 4'hF, 1 + LAT, 99);
      idle(1);
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h5000 + 32'(i);
      burst(1'b1, 32'h200, 7, 1'b1, 4'hF, 1 + LAT, 3);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_outputs", {30'd0, cresp.ready, cresp.last}, 32'd0);
      chk("abort_data", cresp.data, 32'd0);
      creq.valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      for (int i = 0; i < 8; i++) begin
         burst(1'b0, 32'h200 + 32'(4 * i), 0, 1'b1, 4'h0, 1 + LAT, 99);
         chk("abort_word", rbuf[0], (i < 3) ? (32'h5000 + 32'(i)) : (32'h7700 + 32'(i)));
         idle(1);
      end

      // Randomized traffic against the memory model
      gap = 1;
      for (int n = 0; n < 60; n++) begin
         wr   = 1'($urandom_range(0, 1));
         incr = 1'($urandom_range(0, 1));
         len  = $urandom_range(0, 15);
         addr = 32'($urandom_range(0, MW - 1)) << 2;
         strb = 4'($urandom_range(0, 15));
         for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
         burst(wr, addr, len, incr, strb, (gap == 0) ? 2 + LAT : 1 + LAT, 99);
         chk("rand_ready_cycles", 32'(ready_seen), 32'(len + 1));
         chk("rand_last_count", 32'(last_seen), 32'd1);
         gap = $urandom_range(0, 2);
         if (gap > 0) idle(gap);
      end
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
